outbuf_fifo: RTL and testbench

//  Output buffer directly downstream of the PE datapath. Captures each finished output
//  (module_outval) on outbuf_write and returns outbuf_full so the datapath stalls.

---
 rtl/outbuf_pkg.sv | 15 +
 rtl/outbuf_if.sv | 22 ++
 rtl/outbuf_line_ctr.sv | 32 +++
 rtl/outbuf_fifo.sv | 97 +++++++++
 tb/tb_outbuf_fifo.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/outbuf_pkg.sv
// Shared widths, depth and pointer/count types for the PE output buffer.
package outbuf_pkg;
    localparam int OUTBUF_DATA_WIDTH = 17;
    localparam int OUTBUF_DEPTH      = 16;
    localparam int OUTBUF_ADDR_LEN   = $clog2(OUTBUF_DEPTH);
    localparam int OUTBUF_LINE_W     = 8;

    typedef logic [OUTBUF_ADDR_LEN-1:0] ptr_t;
    typedef logic [OUTBUF_ADDR_LEN:0]   cnt_t;

    // Depth is a power of two, so the natural wrap of ptr_t is the circular wrap.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction
endpackage

// File: rtl/outbuf_if.sv
// Push (datapath side) and valid/ready drain (consumer side) signals of the output buffer.
interface outbuf_if import outbuf_pkg::*; #(
    parameter int DATA_WIDTH = OUTBUF_DATA_WIDTH
);
    logic                  outbuf_write;
    logic [DATA_WIDTH-1:0] din;
    logic                  outbuf_full;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport slave (
        input  outbuf_write, din, out_ready,
        output outbuf_full, out_valid, out_data, out_last
    );

    modport master (
        output outbuf_write, din, out_ready,
        input  outbuf_full, out_valid, out_data, out_last
    );
endinterface

// File: rtl/outbuf_line_ctr.sv
// Row framing: counts pops and flags the head word that closes a row of line_len words.
module outbuf_line_ctr import outbuf_pkg::*; #(
    parameter int LINE_W = OUTBUF_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_len,
    input  logic              out_valid,
    input  logic              pop,
    output logic              out_last
);
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [LINE_W-1:0] last_idx;

    // No clamp on line_len changes: a counter already past the new end runs on until it wraps.
    always_comb begin
        last_idx   = line_len - LINE_W'(1);
        out_last   = (line_len != '0) && out_valid && (line_cnt_q == last_idx);
        line_cnt_d = line_cnt_q;
        if (line_len == '0)
            line_cnt_d = '0;
        else if (pop)
            line_cnt_d = out_last ? '0 : line_cnt_q + LINE_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            line_cnt_q <= '0;
        else
            line_cnt_q <= line_cnt_d;
    end
endmodule

// File: rtl/outbuf_fifo.sv
// Circular FWFT output buffer with row framing and sticky overflow/underflow flags.
// Define OUTBUF_LEVEL_EN to add the outbuf_level and outbuf_afull ports.
module outbuf_fifo import outbuf_pkg::*; #(
    parameter int DATA_WIDTH = OUTBUF_DATA_WIDTH,
    parameter int LINE_W     = OUTBUF_LINE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    outbuf_if.slave                  bus,
    input  logic [LINE_W-1:0]        line_len,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
`ifdef OUTBUF_LEVEL_EN
    ,
    output logic [OUTBUF_ADDR_LEN:0] outbuf_level,
    output logic                     outbuf_afull
`endif
);
    localparam cnt_t CNT_FULL  = cnt_t'(OUTBUF_DEPTH);
    localparam cnt_t CNT_AFULL = cnt_t'(OUTBUF_DEPTH - 2);
    localparam cnt_t CNT_ONE   = cnt_t'(1);

    logic [DATA_WIDTH-1:0] mem_q [OUTBUF_DEPTH];

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    cnt_t count_q, count_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    logic full, valid, push, pop;

    // A pop frees a slot only after the edge, so a full FIFO still drops a same-cycle push.
    always_comb begin
        full  = (count_q == CNT_FULL);
        valid = (count_q != '0);
        push  = bus.outbuf_write & ~full;
        pop   = valid & bus.out_ready;

        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        overflow_d  = err_clr ? 1'b0 : (overflow_q  | (bus.outbuf_write & full));
        underflow_d = err_clr ? 1'b0 : (underflow_q | (bus.out_ready & ~valid));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= bus.din;
    end

    outbuf_line_ctr #(
        .LINE_W (LINE_W)
    ) u_line (
        .clk       (clk),
        .rst       (rst),
        .line_len  (line_len),
        .out_valid (valid),
        .pop       (pop),
        .out_last  (bus.out_last)
    );

    assign bus.outbuf_full = full;
    assign bus.out_valid   = valid;
    assign bus.out_data    = valid ? mem_q[rptr_q] : '0;
    assign overflow        = overflow_q;
    assign underflow       = underflow_q;

`ifdef OUTBUF_LEVEL_EN
    assign outbuf_level = count_q;
    assign outbuf_afull = (count_q >= CNT_AFULL);
`endif
endmodule

// File: tb/tb_outbuf_fifo.sv
// Directed vector table plus hand sequences for the output buffer corner cases.
module tb_outbuf_fifo;
    import outbuf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    outbuf_if bus ();
    logic [7:0] line_len;
    logic       overflow, underflow, err_clr;
`ifdef OUTBUF_LEVEL_EN
    logic [OUTBUF_ADDR_LEN:0] outbuf_level;
    logic                     outbuf_afull;
`endif

    outbuf_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .line_len  (line_len),
        .overflow  (overflow),
        .underflow (underflow),
        .err_clr   (err_clr)
`ifdef OUTBUF_LEVEL_EN
        ,
        .outbuf_level (outbuf_level),
        .outbuf_afull (outbuf_afull)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [16:0] din;
        logic        rdy;
        logic        clr;
        logic        e_full;
        logic        e_valid;
        logic [16:0] e_data;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          wr  din      rdy  clr  full valid data     ovf  unf
        tbl[0] = '{1'b1, 17'h00A, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00A, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 17'h00B, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00A, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 17'h00C, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00A, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 17'h000, 1'b1, 1'b0, 1'b0, 1'b1, 17'h00B, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 17'h000, 1'b1, 1'b0, 1'b0, 1'b1, 17'h00C, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 17'h000, 1'b1, 1'b0, 1'b0, 1'b0, 17'h000, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 17'h000, 1'b1, 1'b0, 1'b0, 1'b0, 17'h000, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 17'h000, 1'b0, 1'b1, 1'b0, 1'b0, 17'h000, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 17'h000, 1'b1, 1'b1, 1'b0, 1'b0, 17'h000, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 17'h000, 1'b0, 1'b0, 1'b0, 1'b0, 17'h000, 1'b0, 1'b0};

        bus.outbuf_write = 1'b0;
        bus.din          = '0;
        bus.out_ready    = 1'b0;
        line_len         = 8'd0;
        err_clr          = 1'b0;

        // Reset values
        #12;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_full",  bus.outbuf_full, 1'b0);
        chk("rst_last",  bus.out_last, 1'b0);
        chk("rst_data",  bus.out_data, 17'h0);
        chk("rst_ovf",   overflow, 1'b0);
        chk("rst_unf",   underflow, 1'b0);
        step();
        rst = 1'b0;

        // Basic FWFT, drain, underflow and err_clr priority
        for (int i = 0; i < 10; i++) begin
            bus.outbuf_write = tbl[i].wr;
            bus.din          = tbl[i].din;
            bus.out_ready    = tbl[i].rdy;
            err_clr          = tbl[i].clr;
            step();
            chk($sformatf("v%0d_full", i),  bus.outbuf_full, tbl[i].e_full);
            chk($sformatf("v%0d_valid", i), bus.out_valid, tbl[i].e_valid);
            chk($sformatf("v%0d_data", i),  bus.out_data, tbl[i].e_data);
            chk($sformatf("v%0d_last", i),  bus.out_last, 1'b0);
            chk($sformatf("v%0d_ovf", i),   overflow, tbl[i].e_ovf);
            chk($sformatf("v%0d_unf", i),   underflow, tbl[i].e_unf);
            if (i == 2) chk("t1_count3", dut.count_q, 5'd3);
            if (i == 6) chk("t5_count0", dut.count_q, 5'd0);
        end
        bus.outbuf_write = 1'b0;
        bus.out_ready    = 1'b0;
        err_clr          = 1'b0;

        // Fill to full, overflow on 17th push, ordered drain
        for (int i = 1; i <= 16; i++) begin
            bus.outbuf_write = 1'b1;
            bus.din          = 17'(i);
            step();
            chk($sformatf("t2_full_after_%0d", i), bus.outbuf_full, (i == 16));
        end
        bus.din = 17'h1FF;
        step();
        bus.outbuf_write = 1'b0;
        chk("t2_ovf",    overflow, 1'b1);
        chk("t2_full",   bus.outbuf_full, 1'b1);
        chk("t2_count",  dut.count_q, 5'd16);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("t2_drain_%0d", i), bus.out_data, 17'(i));
            step();
        end
        bus.out_ready = 1'b0;
        chk("t2_empty", bus.out_valid, 1'b0);

        // Full + write + pop in one cycle
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t3_ovf_clr", overflow, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            bus.outbuf_write = 1'b1;
            bus.din          = 17'(i);
            step();
        end
        bus.din       = 17'h1FF;
        bus.out_ready = 1'b1;
        step();
        bus.outbuf_write = 1'b0;
        bus.out_ready    = 1'b0;
        chk("t3_count", dut.count_q, 5'd15);
        chk("t3_full",  bus.outbuf_full, 1'b0);
        chk("t3_ovf",   overflow, 1'b1);
        chk("t3_head",  bus.out_data, 17'h2);
        bus.out_ready = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            chk($sformatf("t3_drain_%0d", i), bus.out_data, 17'(i));
            step();
        end
        bus.out_ready = 1'b0;
        chk("t3_empty", bus.out_valid, 1'b0);

        // Row framing with line_len=3
        line_len = 8'd3;
        for (int i = 1; i <= 7; i++) begin
            bus.outbuf_write = 1'b1;
            bus.din          = 17'(32'h100 + i);
            step();
        end
        bus.outbuf_write = 1'b0;
        bus.out_ready    = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("t4_data_%0d", i), bus.out_data, 17'(32'h100 + i));
            chk($sformatf("t4_last_%0d", i), bus.out_last, (i % 3 == 0));
            step();
        end
        bus.out_ready = 1'b0;
        chk("t4_line_cnt", dut.u_line.line_cnt_q, 8'd1);
        chk("t4_last_empty", bus.out_last, 1'b0);
        line_len = 8'd0;
        step();
        chk("t4_line_cnt_zero", dut.u_line.line_cnt_q, 8'd0);

        // Async reset mid-stream
        err_clr = 1'b1;
        step();
        err_clr       = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t6_unf_set", underflow, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            bus.outbuf_write = 1'b1;
            bus.din          = 17'(32'h40 + i);
            step();
        end
        bus.outbuf_write = 1'b0;
        chk("t6_count5", dut.count_q, 5'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", bus.out_valid, 1'b0);
        chk("t6_rst_full",  bus.outbuf_full, 1'b0);
        chk("t6_rst_ovf",   overflow, 1'b0);
        chk("t6_rst_unf",   underflow, 1'b0);
`ifdef OUTBUF_LEVEL_EN
        chk("t6_rst_level", outbuf_level, 5'd0);
        chk("t6_rst_afull", outbuf_afull, 1'b0);
`endif
        step();
        rst = 1'b0;
        bus.outbuf_write = 1'b1;
        bus.din          = 17'h055;
        step();
        bus.outbuf_write = 1'b0;
        chk("t6_post_valid", bus.out_valid, 1'b1);
        chk("t6_post_data",  bus.out_data, 17'h055);
        chk("t6_post_count", dut.count_q, 5'd1);
`ifdef OUTBUF_LEVEL_EN
        for (int i = 2; i <= 14; i++) begin
            bus.outbuf_write = 1'b1;
            bus.din          = 17'(i);
            step();
            chk($sformatf("t6_afull_%0d", i), outbuf_afull, (i >= 14));
        end
        bus.outbuf_write = 1'b0;
        chk("t6_level14", outbuf_level, 5'd14);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
